mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port memory arbiter and external-bus sequencer for the CRP core. It accepts single-byte read/write requests from the CPU port and an optional loader/debug port, arbitrates round-robin, and serializes each access onto the chip's shared 8-bit multiplexed memory bus as an address-high, address-low, data phase sequence. It sits between the CPU's memory request/read buses and the top-level I/O pins.

## Interface
- ADDR_WIDTH, 15, request address width; must satisfy DATA_WIDTH < ADDR_WIDTH <= 2*DATA_WIDTH-1
- DATA_WIDTH, 8, data and external bus width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cpuReq  in  1  CPU request; held high with cpuAddr/cpuWe/cpuWdata stable until cpuAck
- cpuAddr  in  ADDR_WIDTH  CPU byte address
- cpuWe  in  1  1 = write, 0 = read
- cpuWdata  in  DATA_WIDTH  CPU write data
- cpuAck  out  1  one-cycle completion pulse for CPU
- ldReq, ldAddr, ldWe, ldWdata  in  1/ADDR_WIDTH/1/DATA_WIDTH  loader port, same rules as CPU
- ldAck  out  1  one-cycle completion pulse for loader
- rdata  out  DATA_WIDTH  read data, valid while either ack is high
- extIn  in  DATA_WIDTH  external bus input
- extOut  out  DATA_WIDTH  external bus output value
- extOe  out  1  external bus output enable
- extStbHi, extStbLo, extStbData  out  1 each  phase strobes, one-hot or all zero

## Operation
- FSM: IDLE -> ADDR_HI -> ADDR_LO -> DATA -> DONE -> IDLE.
- IDLE: if any request is high, grant one, latch its addr/we/wdata and port id, go ADDR_HI; else stay.
- Arbitration: one requester wins outright; both high -> port not granted last wins. lastGrant resets to loader, so CPU wins first contention.
- ADDR_HI: extOut = {we, addr[ADDR_WIDTH-1:DATA_WIDTH] zero-extended to DATA_WIDTH-1 bits}, extOe=1, extStbHi=1.
- ADDR_LO: extOut = addr[DATA_WIDTH-1:0], extOe=1, extStbLo=1.
- DATA write: extOut = wdata, extOe=1, extStbData=1. DATA read: extOe=0, extOut=0, extStbData=1; extIn captured into rdata at end of cycle.
- DONE: ack of the granted port high for exactly one cycle; rdata holds captured byte (read) or previous value (write). All strobes/extOe low.
- Requester must drop req (or present a new request) on the edge ending the ack cycle; IDLE re-samples afterward, so no double-grant.
- Requests arriving during ADDR_HI..DONE wait; no preemption, latched fields never change mid-access.
- IDLE/DONE: extOut=0, extOe=0.

## Timing
- Reset values (asynchronous): state IDLE, cpuAck=0, ldAck=0, rdata=0, extOut=0, extOe=0, all strobes 0, lastGrant=loader, latched fields 0.
- All outputs registered or decoded from state and latched fields only; no combinational path from any req/addr/extIn input to any output.
- Latency: req high in cycle 0 (arbiter IDLE) -> ADDR_HI cycle 1, ADDR_LO cycle 2, DATA cycle 3, ack+rdata cycle 4.
- Throughput: one access per 5 cycles; back-to-back from one port: next ADDR_HI no earlier than cycle 6.
- Contending port waits one full access (>= 5 extra cycles).
- Reset asserted mid-access: immediate return to IDLE, strobes/extOe drop asynchronously, access aborted, no ack issued.

## Configuration
- Macro MEM_BUS_ARBITER_LOADER_EN.
- Defined: loader port fully functional as above.
- Undefined: ld* inputs ignored, ldAck tied 0, CPU always granted, lastGrant logic removed; port list unchanged.

## Test plan
- Reset: hold reset=0 mid-DATA of a write -> all outputs 0 immediately; after release, FSM idle, no ack.
- CPU read addr 0x5A3C, extIn=0xC7 during DATA -> extOut 0x5A (stbHi), 0x3C (stbLo), extOe=0 in DATA, cpuAck and rdata=0xC7 in cycle 4.
- CPU write addr 0x0012 data 0x99 -> extOut 0x80, 0x12, 0x99 with extOe=1 on all three phases, cpuAck cycle 4, ldAck stays 0.
- Both ports request from reset, held -> CPU served first, then loader, then CPU; acks alternate, never same cycle.
- Loader write 0x7FFF data 0x01 -> extOut 0xFF, 0xFF, 0x01; with macro undefined same stimulus -> no bus activity, ldAck never asserts.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port (CPU + loader) round-robin arbiter that serializes
// single-byte accesses onto a shared multiplexed bus as address-high,
// address-low and data phases, then acks the granted port for one cycle.
// Optional loader port is enabled by defining MEM_BUS_ARBITER_LOADER_EN;
// without it the ld* inputs are ignored and the CPU is always granted.
// Parameters must satisfy DATA_WIDTH < ADDR_WIDTH <= 2*DATA_WIDTH-1.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic                  cpuWe,
  input  logic [DATA_WIDTH-1:0] cpuWdata,
  output logic                  cpuAck,
  input  logic                  ldReq,
  input  logic [ADDR_WIDTH-1:0] ldAddr,
  input  logic                  ldWe,
  input  logic [DATA_WIDTH-1:0] ldWdata,
  output logic                  ldAck,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] extIn,
  output logic [DATA_WIDTH-1:0] extOut,
  output logic                  extOe,
  output logic                  extStbHi,
  output logic                  extStbLo,
  output logic                  extStbData
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_DATA    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    gnt_ld_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    cpu_ack_q;
  logic                    ld_ack_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   ext_out_q;
  logic                    ext_oe_q;
  logic                    stb_hi_q;
  logic                    stb_lo_q;
  logic                    stb_data_q;

  // Arbitration result and the fields of the winning request.
  logic                    cpu_win;
  logic                    ld_win;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_we;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH-2:0]   sel_hi;

`ifdef MEM_BUS_ARBITER_LOADER_EN
  // 1 = loader owned the most recent grant; contention goes to the other port.
  logic                    last_ld_q;

  // Round-robin pick between the two ports, plus mux of the winner's fields.
  always_comb begin
    cpu_win   = cpuReq && (!ldReq || last_ld_q);
    ld_win    = ldReq && !cpu_win;
    sel_addr  = ld_win ? ldAddr   : cpuAddr;
    sel_we    = ld_win ? ldWe     : cpuWe;
    sel_wdata = ld_win ? ldWdata  : cpuWdata;
    sel_hi    = (DATA_WIDTH-1)'(sel_addr >> DATA_WIDTH);
  end

  // Remember which port was granted last; resets to loader so CPU wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ld_q <= 1'b1;
    end else if (state_q == S_IDLE && (cpu_win || ld_win)) begin
      last_ld_q <= ld_win;
    end
  end
`else
  // Loader disabled: its inputs are deliberately left unconsumed.
  logic unused_ld;
  assign unused_ld = &{1'b0, ldReq, ldAddr, ldWe, ldWdata};

  // CPU is the only possible requester.
  always_comb begin
    cpu_win   = cpuReq;
    ld_win    = 1'b0;
    sel_addr  = cpuAddr;
    sel_we    = cpuWe;
    sel_wdata = cpuWdata;
    sel_hi    = (DATA_WIDTH-1)'(sel_addr >> DATA_WIDTH);
  end
`endif

  // Access sequencer: latches the grant, then drives each bus phase from
  // registers so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      gnt_ld_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cpu_ack_q  <= 1'b0;
      ld_ack_q   <= 1'b0;
      rdata_q    <= '0;
      ext_out_q  <= '0;
      ext_oe_q   <= 1'b0;
      stb_hi_q   <= 1'b0;
      stb_lo_q   <= 1'b0;
      stb_data_q <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      ld_ack_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_win || ld_win) begin
            gnt_ld_q  <= ld_win;
            addr_q    <= sel_addr;
            we_q      <= sel_we;
            wdata_q   <= sel_wdata;
            ext_out_q <= {sel_we, sel_hi};
            ext_oe_q  <= 1'b1;
            stb_hi_q  <= 1'b1;
            state_q   <= S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          ext_out_q <= addr_q[DATA_WIDTH-1:0];
          stb_hi_q  <= 1'b0;
          stb_lo_q  <= 1'b1;
          state_q   <= S_ADDR_LO;
        end
        S_ADDR_LO: begin
          // Reads release the bus during the data phase.
          ext_out_q  <= we_q ? wdata_q : '0;
          ext_oe_q   <= we_q;
          stb_lo_q   <= 1'b0;
          stb_data_q <= 1'b1;
          state_q    <= S_DATA;
        end
        S_DATA: begin
          if (!we_q) begin
            rdata_q <= extIn;
          end
          ext_out_q  <= '0;
          ext_oe_q   <= 1'b0;
          stb_data_q <= 1'b0;
          cpu_ack_q  <= !gnt_ld_q;
          ld_ack_q   <= gnt_ld_q;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpuAck     = cpu_ack_q;
  assign ldAck      = ld_ack_q;
  assign rdata      = rdata_q;
  assign extOut     = ext_out_q;
  assign extOe      = ext_oe_q;
  assign extStbHi   = stb_hi_q;
  assign extStbLo   = stb_lo_q;
  assign extStbData = stb_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed literal checks plus randomized two-port traffic
// compared every cycle against a transaction-level schedule model.
module tb_mem_bus_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpuReq = 1'b0;
  logic [AW-1:0] cpuAddr = '0;
  logic          cpuWe = 1'b0;
  logic [DW-1:0] cpuWdata = '0;
  logic          cpuAck;
  logic          ldReq = 1'b0;
  logic [AW-1:0] ldAddr = '0;
  logic          ldWe = 1'b0;
  logic [DW-1:0] ldWdata = '0;
  logic          ldAck;
  logic [DW-1:0] rdata;
  logic [DW-1:0] extIn = '0;
  logic [DW-1:0] extOut;
  logic          extOe;
  logic          extStbHi;
  logic          extStbLo;
  logic          extStbData;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuWe(cpuWe), .cpuWdata(cpuWdata), .cpuAck(cpuAck),
    .ldReq(ldReq), .ldAddr(ldAddr), .ldWe(ldWe), .ldWdata(ldWdata), .ldAck(ldAck),
    .rdata(rdata), .extIn(extIn), .extOut(extOut), .extOe(extOe),
    .extStbHi(extStbHi), .extStbLo(extStbLo), .extStbData(extStbData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One expected bus cycle: strobes, enable, bus value, acks, read-capture flag.
  typedef struct packed {
    logic          hi;
    logic          lo;
    logic          dat;
    logic          oe;
    logic [DW-1:0] out;
    logic          cack;
    logic          lack;
    logic          cap;
  } exp_t;

  exp_t          exp_q[$];
  bit            m_last_ld = 1'b1;
  logic [DW-1:0] m_rdata = '0;
  bit            chk_en = 1'b0;

  function automatic exp_t mk(bit hi, bit lo, bit dat, bit oe, logic [DW-1:0] out,
                              bit cack, bit lack, bit cap);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dat = dat; e.oe = oe; e.out = out;
    e.cack = cack; e.lack = lack; e.cap = cap;
    return e;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_last_ld = 1'b1;
    m_rdata   = '0;
  endtask

  // On an idle cycle with requests present, pick the winner and schedule the
  // next four cycles of the access.
  task automatic model_grant();
    bit            c, l, win_ld, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d, hi;
    c = cpuReq;
`ifdef MEM_BUS_ARBITER_LOADER_EN
    l = ldReq;
`else
    l = 1'b0;
`endif
    if (!c && !l) return;
    win_ld    = (c && l) ? !m_last_ld : l;
    m_last_ld = win_ld;
    a  = win_ld ? ldAddr : cpuAddr;
    w  = win_ld ? ldWe : cpuWe;
    d  = win_ld ? ldWdata : cpuWdata;
    hi = DW'(a >> DW);
    hi[DW-1] = w;
    exp_q.push_back(mk(1, 0, 0, 1, hi, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 1, a[DW-1:0], 0, 0, 0));
    exp_q.push_back(mk(0, 0, 1, w, w ? d : '0, 0, 0, !w));
    exp_q.push_back(mk(0, 0, 0, 0, '0, !win_ld, win_ld, 0));
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    exp_t e;
    bit   busy;
    if (chk_en) begin
      busy = (exp_q.size() != 0);
      e = busy ? exp_q.pop_front() : '0;
      chk("cycle", {extStbHi, extStbLo, extStbData, extOe, extOut, cpuAck, ldAck, rdata},
                   {e.hi, e.lo, e.dat, e.oe, e.out, e.cack, e.lack, m_rdata});
      if (e.cap) m_rdata = extIn;
      if (!busy) model_grant();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b0;
    cpuReq = 1'b0;
    ldReq  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  // One directed access with literal per-phase expectations.
  task automatic access(input string nm, input bit ld, input logic [AW-1:0] a, input bit w,
                        input logic [DW-1:0] wd, input logic [DW-1:0] ev,
                        input logic [DW-1:0] e_hi, input logic [DW-1:0] e_lo,
                        input logic [DW-1:0] e_dat, input logic [DW-1:0] e_rd);
    @(posedge clk); #1;
    extIn = ev;
    if (ld) begin ldReq = 1; ldAddr = a; ldWe = w; ldWdata = wd; end
    else begin cpuReq = 1; cpuAddr = a; cpuWe = w; cpuWdata = wd; end
    @(negedge clk);
    chk({nm, "_c0"}, {extStbHi, extOe}, 2'b00);
    @(negedge clk);
    chk({nm, "_hi"}, {extStbHi, extStbLo, extStbData, extOe, extOut}, {4'b1001, e_hi});
    @(negedge clk);
    chk({nm, "_lo"}, {extStbHi, extStbLo, extStbData, extOe, extOut}, {4'b0101, e_lo});
    @(negedge clk);
    chk({nm, "_data"}, {extStbHi, extStbLo, extStbData, extOe, extOut}, {3'b001, w, e_dat});
    @(negedge clk);
    chk({nm, "_done"}, {extStbHi, extStbLo, extStbData, extOe, extOut, cpuAck, ldAck, rdata},
                       {4'b0000, 8'h00, !ld, ld, e_rd});
    @(posedge clk); #1;
    cpuReq = 0;
    ldReq  = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ack_ids[$];
    bit cpu_ack_prev, ld_ack_prev;

    #1;
    chk("reset_outputs", {extStbHi, extStbLo, extStbData, extOe, extOut, cpuAck, ldAck, rdata}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    chk_en = 1'b1;

    access("cpu_read",  0, 15'h5A3C, 0, 8'h00, 8'hC7, 8'h5A, 8'h3C, 8'h00, 8'hC7);
    access("cpu_write", 0, 15'h0012, 1, 8'h99, 8'h3E, 8'h80, 8'h12, 8'h99, 8'hC7);

`ifdef MEM_BUS_ARBITER_LOADER_EN
    access("ld_write", 1, 15'h7FFF, 1, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'hC7);
`else
    @(posedge clk); #1;
    ldReq = 1; ldAddr = 15'h7FFF; ldWe = 1; ldWdata = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ld_ignored", {extStbHi, extStbLo, extStbData, extOe, ldAck}, 5'b0);
    end
    @(posedge clk); #1;
    ldReq = 0;
`endif

    // Contention from reset with both requests held.
    do_reset();
    cpuReq = 1; cpuAddr = 15'h0101; cpuWe = 0;
    ldReq  = 1; ldAddr  = 15'h0202; ldWe  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("ack_both", {1'b0, cpuAck & ldAck}, 2'b00);
      if (cpuAck) ack_ids.push_back(0);
      if (ldAck)  ack_ids.push_back(1);
    end
    @(posedge clk); #1;
    cpuReq = 0; ldReq = 0;
    chk("contend_count", ack_ids.size(), 3);
`ifdef MEM_BUS_ARBITER_LOADER_EN
    chk("contend_order", {ack_ids[0][0], ack_ids[1][0], ack_ids[2][0]}, 3'b010);
`else
    chk("contend_order", {ack_ids[0][0], ack_ids[1][0], ack_ids[2][0]}, 3'b000);
`endif
    repeat (6) @(posedge clk);

    // Reset asserted in the data phase of a write.
    @(posedge clk); #1;
    cpuReq = 1; cpuAddr = 15'h1234; cpuWe = 1; cpuWdata = 8'hA5;
    repeat (4) @(negedge clk);
    chk("rst_pre_data", {extStbData, extOe, extOut}, {2'b11, 8'hA5});
    #1;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_async", {extStbHi, extStbLo, extStbData, extOe, extOut, cpuAck, ldAck, rdata}, '0);
    cpuReq = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_ack", {cpuAck, ldAck, extStbHi}, 3'b000);
    end

    // Randomized two-port traffic checked by the model.
    cpu_ack_prev = 0;
    ld_ack_prev  = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (cpu_ack_prev || (!cpuReq && $urandom_range(3) == 0)) begin
        cpuReq   = cpu_ack_prev ? 1'($urandom) : 1'b1;
        cpuAddr  = AW'($urandom);
        cpuWe    = 1'($urandom);
        cpuWdata = DW'($urandom);
      end
      if (ld_ack_prev || (!ldReq && $urandom_range(3) == 0)) begin
        ldReq   = ld_ack_prev ? 1'($urandom) : 1'b1;
        ldAddr  = AW'($urandom);
        ldWe    = 1'($urandom);
        ldWdata = DW'($urandom);
      end
      extIn = DW'($urandom);
      cpu_ack_prev = cpuAck;
      ld_ack_prev  = ldAck;
    end
    cpuReq = 0;
    ldReq  = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
